// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and the fetch queue entry type for the fetch front end.
package cpu_pkg;
  localparam int          INSTR_BYTES        = 4;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'd100;
  localparam int          IMEM_BYTES_DEFAULT = 16384;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched entries with a single-cycle flush.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  assign dout  = mem[rd_ptr];
  assign empty = count == '0;
  assign full  = count == (AW+1)'(DEPTH);
  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer feeding a fetch queue, with redirect flush and sticky PC fault.
module instr_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IMEM_BYTES = IMEM_BYTES_DEFAULT,
  parameter int          QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fault
);
  localparam int CW = $clog2(QDEPTH) + 1;
  logic [31:0]   pc_q;
  logic          legal, push, pop, empty, full;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  // 33-bit compare so a PC near 2^32 cannot wrap into the legal range.
  assign legal     = pc_q[1:0] == 2'b00 && ({1'b0, pc_q} + 33'd3 < 33'(IMEM_BYTES));
  assign pop       = out_ready && !empty;
  assign push      = !redirect_valid && !fault && !halt && legal && (!full || pop);
  assign out_valid = count != '0;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign imem_addr = pc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      fault <= 1'b0;
    end else if (redirect_valid) begin
      pc_q  <= redirect_pc;
      fault <= 1'b0;
    end else begin
      if (!halt && !legal) fault <= 1'b1;
      if (push) pc_q <= pc_q + 32'(INSTR_BYTES);
    end
  end
  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ('{pc: pc_q, instr: imem_instr}),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_instr_fetch_ctrl;
  import cpu_pkg::*;
  localparam int          IMEM = 16384;
  localparam logic [31:0] RPC  = 32'd100;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] imem_addr, imem_instr, redirect_pc = '0, out_instr, out_pc;
  logic        halt = 1'b0, redirect_valid = 1'b0, out_valid, out_ready = 1'b0, fault;
  logic [31:0] mem [IMEM/4];
  int          n_chk = 0, n_fail = 0;
  fetch_entry_t q [$];
  logic [31:0] m_pc, last_pc;
  bit          m_fault, have_last;
  instr_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .fault(fault)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'(IMEM)) ? mem[a[13:2]] : 32'hdeadbeef;
  endfunction
  assign imem_instr = mem_word(imem_addr);
  function automatic bit legal(input logic [31:0] p);
    return p[1:0] == 2'b00 && (64'(p) + 64'd3 < 64'(IMEM));
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_pc = RPC;
    m_fault = 0;
    have_last = 0;
  endtask
  task automatic model_step(input bit rdy, input bit hlt, input bit rv, input logic [31:0] rpc);
    bit pop, do_push;
    pop = q.size() != 0 && rdy;
    if (rv) begin
      q.delete();
      m_pc = rpc;
      m_fault = 0;
    end else begin
      do_push = !m_fault && !hlt && legal(m_pc) && (q.size() < 2 || pop);
      if (!hlt && !legal(m_pc)) m_fault = 1;
      if (pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask
  task automatic compare();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].instr);
      chk("instr_vs_mem", out_instr, mem_word(out_pc));
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("fault", 32'(fault), 32'(m_fault));
  endtask
  // Called at a falling edge: drive inputs, advance one clock, check at the next falling edge.
  task automatic cyc(input bit rdy, input bit hlt, input bit rv, input logic [31:0] rpc);
    out_ready = rdy;
    halt = hlt;
    redirect_valid = rv;
    redirect_pc = rpc;
    if (out_valid && rdy) begin
      if (have_last) chk("pc_seq", out_pc, last_pc + 32'd4);
      last_pc = out_pc;
      have_last = 1;
    end
    if (rv) have_last = 0;
    @(posedge clk);
    model_step(rdy, hlt, rv, rpc);
    @(negedge clk);
    compare();
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    model_reset();
    out_ready = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    compare();
  endtask
  logic [31:0] rpc, frozen;
  initial begin
    for (int i = 0; i < IMEM/4; i++) mem[i] = $urandom;
    mem[25]  = 32'h48080000;
    mem[26]  = 32'h48090004;
    mem[129] = 32'h1674fffb;
    model_reset();
    @(negedge clk);
    async_reset();
    // 1: streaming from reset
    chk("t1_addr", imem_addr, 32'd100);
    cyc(1, 0, 0, 0);
    chk("t1_pc0", out_pc, 32'd100);
    chk("t1_in0", out_instr, 32'h48080000);
    cyc(1, 0, 0, 0);
    chk("t1_pc1", out_pc, 32'd104);
    chk("t1_in1", out_instr, 32'h48090004);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    // 2: backpressure from release
    @(negedge clk);
    async_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    chk("t2_addr", imem_addr, 32'd108);
    chk("t2_head", out_pc, 32'd100);
    cyc(1, 0, 0, 0);
    chk("t2_pc1", out_pc, 32'd104);
    cyc(1, 0, 0, 0);
    chk("t2_pc2", out_pc, 32'd108);
    // 3: redirect with a full queue and a same-cycle pop
    async_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 32'd516);
    chk("t3_gap", 32'(out_valid), 32'd0);
    cyc(1, 0, 0, 0);
    chk("t3_pc", out_pc, 32'd516);
    chk("t3_in", out_instr, 32'h1674fffb);
    // 4: misaligned redirect faults, a legal redirect recovers
    cyc(1, 0, 1, 32'h202);
    cyc(1, 0, 0, 0);
    chk("t4_fault", 32'(fault), 32'd1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_addr", imem_addr, 32'h202);
    cyc(1, 0, 1, 32'd600);
    chk("t4_clear", 32'(fault), 32'd0);
    cyc(1, 0, 0, 0);
    chk("t4_pc", out_pc, 32'd600);
    // 5: run off the end of memory
    cyc(1, 0, 1, 32'd16376);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
    chk("t5_fault", 32'(fault), 32'd1);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_addr", imem_addr, 32'd16384);
    // 6: halt mid-stream
    cyc(1, 0, 1, 32'd1000);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    frozen = imem_addr;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    chk("t6_frozen", imem_addr, frozen);
    chk("t6_drained", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    // 7: asynchronous reset mid-stream
    async_reset();
    cyc(1, 0, 0, 0);
    chk("t7_pc", out_pc, 32'd100);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       rpc = {18'd0, 12'($urandom), 2'b10};
        1:       rpc = 32'(IMEM) - 32'($urandom_range(1, 3) * 4);
        2:       rpc = 32'hfffffffc;
        default: rpc = {18'd0, 12'($urandom), 2'b00};
      endcase
      if ($urandom_range(0, 199) == 0) async_reset();
      else cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, rpc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
